// File: rtl/score_bcd_display_pkg.sv
// Shared types and constants for the score BCD display: FSM states and
// active-low seven-segment codes (bit 0 = segment a).
package score_bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_CODES [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Non-decimal nibbles show blank rather than garbage.
  function automatic logic [6:0] seg7_code(input logic [3:0] d);
    case (d)
      4'd0:    seg7_code = SEG_CODES[0];
      4'd1:    seg7_code = SEG_CODES[1];
      4'd2:    seg7_code = SEG_CODES[2];
      4'd3:    seg7_code = SEG_CODES[3];
      4'd4:    seg7_code = SEG_CODES[4];
      4'd5:    seg7_code = SEG_CODES[5];
      4'd6:    seg7_code = SEG_CODES[6];
      4'd7:    seg7_code = SEG_CODES[7];
      4'd8:    seg7_code = SEG_CODES[8];
      4'd9:    seg7_code = SEG_CODES[9];
      default: seg7_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_bcd_display_if.sv
// Signal bundle between the score source/processor (master) and the display
// converter (slave).
interface score_bcd_display_if #(
  parameter int NUM_DIGITS = 3,
  parameter int IN_WIDTH   = 32
);
  logic [IN_WIDTH-1:0]     score_in;
  logic                    score_valid;
  logic                    gameover_flag;
  logic                    mode_sel;
  logic                    busy;
  logic                    done;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [7*NUM_DIGITS-1:0] seg_out;
  logic                    overflow;
  logic [IN_WIDTH-1:0]     high_score;

  modport master (
    output score_in, score_valid, gameover_flag, mode_sel,
    input  busy, done, bcd_out, seg_out, overflow, high_score
  );

  modport slave (
    input  score_in, score_valid, gameover_flag, mode_sel,
    output busy, done, bcd_out, seg_out, overflow, high_score
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational decode of one BCD digit to an active-low seven-segment code.
module bcd_to_seg7
  import score_bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg7_code(bcd_i);
  end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to BCD/seven-segment display via shift-add-3, with high-score
// tracking and a one-deep pending request; latency IN_WIDTH+2 cycles to done.
module score_bcd_display
  import score_bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 3,
  parameter int IN_WIDTH      = 32,
  parameter int BLANK_LEADING = 1
) (
  input logic          clock,
  input logic          reset,
  score_bcd_display_if.slave bus
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  function automatic logic [SW-1:0] seg_reset_val();
    logic [SW-1:0] v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v[7*i +: 7] = (i == 0 || BLANK_LEADING == 0) ? SEG_CODES[0] : SEG_BLANK;
    end
    return v;
  endfunction

  localparam logic [SW-1:0] SEG_RST = seg_reset_val();

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] src_q, src_d;
  logic [BW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [SW-1:0]       seg_q, seg_d;
  logic                ovf_q, ovf_d;
  logic [IN_WIDTH-1:0] hs_q, hs_d;
  logic                pend_q, pend_d;
  logic                gov_q, gov_d;
  logic                armed_q, armed_d;
  logic                mode_q, mode_d;

  logic [BW-1:0] acc_adj;
  logic [BW-1:0] disp_bcd;
  logic [SW-1:0] seg_raw;
  logic [SW-1:0] seg_disp;
  logic          gov_edge;
  logic          hs_upd;
  logic          pend_set;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                     : acc_q[4*i +: 4];
    end
  end

  assign disp_bcd = ovf_acc_q ? {NUM_DIGITS{4'h9}} : acc_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .bcd_i (disp_bcd[4*g +: 4]),
      .seg_o (seg_raw[7*g +: 7])
    );
  end

  // Blank zeros above the most significant non-zero digit; digit 0 always shows.
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    seg_disp = seg_raw;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (disp_bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (BLANK_LEADING != 0 && !seen_nz) seg_disp[7*i +: 7] = SEG_BLANK;
    end
  end

  // armed_q masks the first post-reset cycle so a flag held through reset is not an event.
  assign gov_edge = bus.gameover_flag & ~gov_q & armed_q;
  assign hs_upd   = gov_edge && (bus.score_in > hs_q);
  assign pend_set = ((state_q != ST_IDLE) &&
                     (bus.score_valid || (bus.mode_sel != mode_q))) ||
                    (hs_upd && bus.mode_sel);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    seg_d     = seg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    hs_d      = hs_upd ? bus.score_in : hs_q;
    gov_d     = bus.gameover_flag;
    armed_d   = 1'b1;
    mode_d    = bus.mode_sel;

    case (state_q)
      ST_IDLE: begin
        if (bus.score_valid || pend_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        src_d     = bus.mode_sel ? hs_q : bus.score_in;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        acc_d     = {acc_adj[BW-2:0], src_q[IN_WIDTH-1]};
        src_d     = src_q << 1;
        ovf_acc_d = ovf_acc_q | acc_adj[BW-1];
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(IN_WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = disp_bcd;
        seg_d   = seg_disp;
        ovf_d   = ovf_acc_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A set in the LOAD cycle survives the clear so the new data is re-converted.
    pend_d = (pend_q && (state_q != ST_LOAD)) || pend_set;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      seg_q     <= SEG_RST;
      ovf_q     <= 1'b0;
      hs_q      <= '0;
      pend_q    <= 1'b0;
      gov_q     <= 1'b0;
      armed_q   <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      seg_q     <= seg_d;
      ovf_q     <= ovf_d;
      hs_q      <= hs_d;
      pend_q    <= pend_d;
      gov_q     <= gov_d;
      armed_q   <= armed_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.seg_out    = seg_q;
  assign bus.overflow   = ovf_q;
  assign bus.high_score = hs_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display: vector table of conversions plus
// hand sequences for high score, pending merge, game-over/LOAD race and reset abort.
module tb_score_bcd_display;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  score_bcd_display_if #(.NUM_DIGITS(3), .IN_WIDTH(32)) bus ();

  score_bcd_display #(.NUM_DIGITS(3), .IN_WIDTH(32), .BLANK_LEADING(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [20:0] SEG_RST_EXP = {7'h7F, 7'h7F, 7'h40};

  typedef struct {
    logic [31:0] score;
    logic [11:0] bcd;
    logic [20:0] seg;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_conv(input logic [31:0] v, input logic msel);
    logic [11:0] prev_bcd;
    int lat;
    prev_bcd = bus.bcd_out;
    bus.score_in    = v;
    bus.mode_sel    = msel;
    bus.score_valid = 1'b1;
    @(posedge clock); #1;
    bus.score_valid = 1'b0;
    chk("busy_in_load", bus.busy, 1);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (n == 12) chk("bcd_hold", bus.bcd_out, prev_bcd);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, 34);
    chk("busy_at_done", bus.busy, 0);
    @(posedge clock); #1;
    chk("done_width", bus.done, 0);
  endtask

  initial begin
    int dones;
    logic [11:0] first_bcd;
    logic [11:0] second_bcd;

    vecs[0] = '{32'd123,        12'h123, {7'h79, 7'h24, 7'h30}, 1'b0};
    vecs[1] = '{32'd7,          12'h007, {7'h7F, 7'h7F, 7'h78}, 1'b0};
    vecs[2] = '{32'd0,          12'h000, {7'h7F, 7'h7F, 7'h40}, 1'b0};
    vecs[3] = '{32'd1000,       12'h999, {7'h10, 7'h10, 7'h10}, 1'b1};
    vecs[4] = '{32'd999,        12'h999, {7'h10, 7'h10, 7'h10}, 1'b0};
    vecs[5] = '{32'd105,        12'h105, {7'h79, 7'h40, 7'h12}, 1'b0};
    vecs[6] = '{32'd60,         12'h060, {7'h7F, 7'h02, 7'h40}, 1'b0};
    vecs[7] = '{32'd48,         12'h048, {7'h7F, 7'h19, 7'h00}, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF,  12'h999, {7'h10, 7'h10, 7'h10}, 1'b1};

    bus.score_in      = '0;
    bus.score_valid   = 1'b0;
    bus.gameover_flag = 1'b0;
    bus.mode_sel      = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_bcd", bus.bcd_out, 12'h000);
    chk("rst_seg", bus.seg_out, SEG_RST_EXP);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_hs", bus.high_score, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("post_rst_busy", bus.busy, 0);

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].score, 1'b0);
      chk($sformatf("bcd[%0d]", i), bus.bcd_out, vecs[i].bcd);
      chk($sformatf("seg[%0d]", i), bus.seg_out, vecs[i].seg);
      chk($sformatf("ovf[%0d]", i), bus.overflow, vecs[i].ovf);
    end

    // High score follows only strictly larger scores on game-over edges.
    bus.score_in = 32'd45; bus.gameover_flag = 1'b1;
    @(posedge clock); #1;
    chk("hs_first", bus.high_score, 45);
    bus.gameover_flag = 1'b0;
    @(posedge clock); #1;
    bus.score_in = 32'd30; bus.gameover_flag = 1'b1;
    @(posedge clock); #1;
    chk("hs_keep", bus.high_score, 45);
    bus.gameover_flag = 1'b0;
    @(posedge clock); #1;

    run_conv(32'd999, 1'b1);
    chk("hs_disp_bcd", bus.bcd_out, 12'h045);
    chk("hs_disp_seg", bus.seg_out, {7'h7F, 7'h19, 7'h12});
    bus.mode_sel = 1'b0;
    @(posedge clock); #1;

    // Three requests while busy merge into one extra conversion of the last score.
    bus.score_in = 32'd111; bus.score_valid = 1'b1;
    @(posedge clock); #1;
    bus.score_valid = 1'b0;
    dones = 0; first_bcd = '0;
    for (int n = 1; n <= 120; n++) begin
      if (n == 5)       begin bus.score_in = 32'd200; bus.score_valid = 1'b1; end
      else if (n == 8)  begin bus.score_in = 32'd300; bus.score_valid = 1'b1; end
      else if (n == 12) begin bus.score_in = 32'd456; bus.score_valid = 1'b1; end
      else bus.score_valid = 1'b0;
      @(posedge clock); #1;
      if (bus.done) begin
        dones++;
        if (dones == 1) first_bcd = bus.bcd_out;
      end
    end
    bus.score_valid = 1'b0;
    chk("merge_dones", dones, 2);
    chk("merge_first", first_bcd, 12'h111);
    chk("merge_final", bus.bcd_out, 12'h456);

    // Game-over edge in the LOAD cycle: old high score shown, then re-converted.
    bus.score_in = 32'd77; bus.mode_sel = 1'b1; bus.score_valid = 1'b1;
    @(posedge clock); #1;
    bus.score_valid = 1'b0; bus.gameover_flag = 1'b1;
    @(posedge clock); #1;
    chk("race_hs", bus.high_score, 77);
    dones = 0; first_bcd = '0; second_bcd = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (bus.done) begin
        dones++;
        if (dones == 1) first_bcd = bus.bcd_out;
        if (dones == 2) second_bcd = bus.bcd_out;
      end
    end
    chk("race_dones", dones, 2);
    chk("race_first", first_bcd, 12'h045);
    chk("race_second", second_bcd, 12'h077);
    bus.gameover_flag = 1'b0; bus.mode_sel = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset in SHIFT cycle 10, with the game-over flag held high through reset.
    bus.score_in = 32'd222; bus.score_valid = 1'b1; bus.gameover_flag = 1'b1;
    @(posedge clock); #1;
    bus.score_valid = 1'b0;
    repeat (11) begin
      @(posedge clock); #1;
    end
    chk("abort_busy_pre", bus.busy, 1);
    chk("abort_hs_pre", bus.high_score, 222);
    reset = 1'b1;
    #1;
    chk("abort_bcd", bus.bcd_out, 12'h000);
    chk("abort_seg", bus.seg_out, SEG_RST_EXP);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ovf", bus.overflow, 0);
    chk("abort_hs", bus.high_score, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    dones = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("held_flag_no_event", bus.high_score, 0);
    bus.gameover_flag = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_display.md
SCORE_BCD_DISPLAY -- requirements
Module: score_bcd_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3: number of decimal digits displayed (1..10).
REQ-002 SHALL have parameter IN_WIDTH, default 32: binary score width.
REQ-003 SHALL have parameter BLANK_LEADING, default 1: 1 blanks leading zeros, 0 shows them.
REQ-004 SHALL have port clock, input, 1: sole clock, all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port score_in, input, IN_WIDTH: current game score, binary.
REQ-007 SHALL have port score_valid, input, 1: request conversion of the selected source.
REQ-008 SHALL have port gameover_flag, input, 1: level from the processor; its rising edge is a game-over event.
REQ-009 SHALL have port mode_sel, input, 1: 0 displays the current score, 1 displays the high score.
REQ-010 SHALL have port busy, output, 1: conversion in progress.
REQ-011 SHALL have port done, output, 1: single-cycle pulse when the display registers update.
REQ-012 SHALL have port bcd_out, output, 4*NUM_DIGITS: registered BCD; digit 0 is in bits [3:0].
REQ-013 SHALL have port seg_out, output, 7*NUM_DIGITS: registered active-low seven-segment code; bit 0 = segment a; digit 0 is in bits [6:0].
REQ-014 SHALL have port overflow, output, 1: displayed value exceeded 10^NUM_DIGITS-1.
REQ-015 SHALL have port high_score, output, IN_WIDTH: registered best score.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
REQ-017 IDLE: SHALL go to LOAD when score_valid=1 or the pending flag is set.
REQ-018 LOAD: SHALL capture the source (mode_sel ? high_score : score_in), clear the BCD accumulator, and clear the pending flag.
REQ-019 SHIFT: each cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, source} left by 1, for exactly IN_WIDTH cycles.
REQ-020 SHIFT: SHALL set a sticky overflow bit if any bit shifted out of the top digit is 1.
REQ-021 DONE: SHALL update bcd_out, seg_out and overflow together, pulse done for one cycle, and return to IDLE.
REQ-022 Latency from score_valid sampled in IDLE to the done pulse SHALL be IN_WIDTH+2 cycles.
REQ-023 busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-024 Outputs SHALL hold their previous values during conversion, so the display never shows partial results.
REQ-025 On overflow, bcd_out SHALL be all digits 9, with seg_out to match.
REQ-026 With BLANK_LEADING=1, every zero digit above the most significant non-zero digit SHALL show 7'h7F (blank); digit 0 SHALL never be blanked.
REQ-027 score_valid or a mode_sel change while busy SHALL set a one-deep pending flag; no request SHALL be lost.
REQ-028 Multiple requests while busy SHALL merge into a single pending conversion.
REQ-029 On a gameover_flag rising edge, if score_in > high_score (unsigned), high_score SHALL load score_in on the next cycle.
REQ-030 A high_score update while mode_sel=1 SHALL set the pending flag.
REQ-031 A simultaneous game-over edge and LOAD SHALL capture the pre-update high_score; the pending flag then triggers re-conversion.

Reset
REQ-032 Asynchronous reset SHALL force the following: FSM to IDLE; busy=0; done=0; overflow=0; pending=0; high_score=0; bcd_out=0.
REQ-033 Reset SHALL force seg_out to "0" on digit 0 and blank on all other digits when BLANK_LEADING=1, otherwise "0" on every digit.
REQ-034 Reset mid-conversion SHALL abort the conversion with no done pulse.
REQ-035 The gameover_flag edge detector SHALL reset to 0, so that a flag held high through reset produces no event.

Structure
REQ-036 The shared package SHALL hold the FSM state enum, the active-low segment codes for 0-9, and the SEG_BLANK constant 7'h7F.
REQ-037 The design SHALL use one combinational sub-module, bcd_to_seg7 (4-bit BCD in, 7-bit active-low segments out), instantiated NUM_DIGITS times.

Verification
REQ-038 score_in=123, score_valid pulse -> done after 34 cycles; bcd_out=12'h123; seg_out = "1","2","3"; overflow=0.
REQ-039 score_in=7 with BLANK_LEADING=1 -> digits 2 and 1 = 7'h7F, digit 0 = "7".
REQ-039 (cont.) score_in=0 -> digit 0 = "0", digits 2 and 1 blank.
REQ-040 score_in=1000, NUM_DIGITS=3 -> overflow=1, bcd_out=12'h999.
REQ-041 score_in=45, gameover rising edge -> high_score=45; then score_in=30 with a second edge -> high_score stays 45.
REQ-042 mode_sel=1, then score_valid=1 -> bcd_out=12'h045.
REQ-043 score_valid pulsed 3 times while busy -> exactly one extra conversion, using the final score_in.
REQ-044 Reset asserted at SHIFT cycle 10 -> no done pulse; outputs return to their reset values immediately.
